// File: rtl/addsub_pipe.sv
// Pipelined N-bit adder/subtractor with carry/borrow, signed overflow and result flags.
// Optional saturation input `sat` is present only when ADDSUB_SAT_EN is defined.
module addsub_pipe #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  input  logic         sgn,
`ifdef ADDSUB_SAT_EN
  input  logic         sat,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         neg
);

  localparam int unsigned W = N + 4;

  logic [N:0]   raw;
  logic [N-1:0] res;
  logic         carry;
  logic         sovf;
  logic [W-1:0] bundle;
  logic         accept;

  always_comb begin
    if (op) begin
      raw  = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, cin};
      sovf = sgn & (a[N-1] ^ b[N-1]) & (raw[N-1] ^ a[N-1]);
    end else begin
      raw  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
      sovf = sgn & ~(a[N-1] ^ b[N-1]) & (raw[N-1] ^ a[N-1]);
    end
    // Bit N is the carry for add and the borrow for sub.
    carry = raw[N];
    res   = raw[N-1:0];
`ifdef ADDSUB_SAT_EN
    if (sat) begin
      // A overflowing signed result always has the sign opposite to a.
      if (sgn && sovf) begin
        res = a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end else if (!sgn && carry) begin
        res = op ? '0 : '1;
      end
    end
`endif
    bundle = {res, carry, sovf, ~|res, sgn & res[N-1]};
  end

  logic [STAGES-1:0] vld_q;
  logic [W-1:0]      dat_q [STAGES];
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] stg_v;
  logic [W-1:0]      stg_d [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    // A stage may load whenever some stage at or below it has room, or the sink drains.
    assign ld[i] = out_ready | ~&vld_q[STAGES-1:i];
    if (i == 0) begin : g_head
      assign stg_v[i] = accept;
      assign stg_d[i] = bundle;
    end else begin : g_body
      assign stg_v[i] = vld_q[i-1];
      assign stg_d[i] = dat_q[i-1];
    end
  end

  assign in_ready = ~rst & ld[0];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld[i]) begin
          vld_q[i] <= stg_v[i];
          if (stg_v[i]) dat_q[i] <= stg_d[i];
        end
      end
    end
  end

  assign out_valid                  = vld_q[STAGES-1];
  assign {s, cout, ovf, zero, neg} = dat_q[STAGES-1];

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: one STAGES=2 and one STAGES=1 instance (N=32) fed from shared
// operand inputs, each checked against an arithmetic reference model and a result queue.
module tb_addsub_pipe;

`ifdef ADDSUB_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif
  localparam longint SMax = 64'sh7FFF_FFFF;
  localparam longint SMin = -64'sh8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a, b;
  logic        cin, op, sgn, sat;
  logic        in_ready1, in_ready2, out_ready1, out_ready2, out_valid1, out_valid2;
  logic [31:0] s1, s2;
  logic        cout1, ovf1, zero1, neg1, cout2, ovf2, zero2, neg2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] q1[$];
  logic [35:0] q2[$];
  logic [31:0] corner [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  always #5 clk = ~clk;

  addsub_pipe #(.N(32), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
    .cin(cin), .op(op), .sgn(sgn),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid2), .out_ready(out_ready2), .s(s2), .cout(cout2), .ovf(ovf2),
    .zero(zero2), .neg(neg2)
  );

  addsub_pipe #(.N(32), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .a(a), .b(b),
    .cin(cin), .op(op), .sgn(sgn),
`ifdef ADDSUB_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .s(s1), .cout(cout1), .ovf(ovf1),
    .zero(zero1), .neg(neg1)
  );

  // Reference: exact integer arithmetic, then wrap or clamp.
  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mcin, input logic mop, input logic msgn,
                                        input logic msat);
    longint unsigned ua, ub, uc, ur;
    longint          ta, tb, tc, tr;
    logic            c, o;
    logic [31:0]     r;
    ua = ma; ub = mb; uc = mcin;
    ta = signed'(ma); tb = signed'(mb); tc = mcin;
    if (!mop) begin
      ur = ua + ub + uc;
      c  = (ur > 64'hFFFF_FFFF);
      tr = ta + tb + tc;
    end else begin
      c  = (ua < ub + uc);
      ur = ua - ub - uc;
      tr = ta - tb - tc;
    end
    r = ur[31:0];
    o = msgn && (tr > SMax || tr < SMin);
    if (SatEn && msat) begin
      if (msgn && o) r = (tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else if (!msgn && c) r = mop ? 32'h0 : 32'hFFFF_FFFF;
    end
    return {r, c, o, (r == 32'h0), msgn & r[31]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score both outputs, record acceptances, advance to just after posedge.
  task automatic step();
    logic acc1, acc2, r;
    @(negedge clk);
    if (out_valid2 === 1'b1) begin
      if (q2.size() == 0) check("dut2_extra_result", 64'(out_valid2), 64'd0);
      else begin
        check("dut2_result", 64'({s2, cout2, ovf2, zero2, neg2}), 64'(q2[0]));
        if (out_ready2) void'(q2.pop_front());
      end
    end
    if (out_valid1 === 1'b1) begin
      if (q1.size() == 0) check("dut1_extra_result", 64'(out_valid1), 64'd0);
      else begin
        check("dut1_result", 64'({s1, cout1, ovf1, zero1, neg1}), 64'(q1[0]));
        if (out_ready1) void'(q1.pop_front());
      end
    end
    acc2 = (in_valid && in_ready2 === 1'b1);
    acc1 = (in_valid && in_ready1 === 1'b1);
    if (acc2) q2.push_back(model(a, b, cin, op, sgn, sat));
    if (acc1) q1.push_back(model(a, b, cin, op, sgn, sat));
    r = rst;
    @(posedge clk);
    if (r) begin
      q1.delete();
      q2.delete();
    end
    #1;
  endtask

  task automatic set_rand();
    a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
    b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
    cin = 1'($urandom);
    op  = 1'($urandom);
    sgn = 1'($urandom);
    sat = 1'($urandom);
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                       input logic vop, input logic vsgn, input logic vsat);
    a = va; b = vb; cin = vc; op = vop; sgn = vsgn; sat = vsat; in_valid = 1'b1;
  endtask

  initial begin
    int sent;
    rst = 1'b1; in_valid = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
    set_rand();
    #1;
    check("in_ready2_in_reset", 64'(in_ready2), 64'd0);
    check("in_ready1_in_reset", 64'(in_ready1), 64'd0);
    repeat (3) step();
    check("reset_out2", 64'({out_valid2, s2, cout2, ovf2, zero2, neg2}), 64'd0);
    check("reset_out1", 64'({out_valid1, s1, cout1, ovf1, zero1, neg1}), 64'd0);
    check("in_ready2_held_reset", 64'(in_ready2), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("in_ready2_after_reset", 64'(in_ready2), 64'd1);
    check("in_ready1_after_reset", 64'(in_ready1), 64'd1);

    // Unsigned add wraps to zero with carry.
    drive(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    check("lat2_not_yet", 64'(out_valid2), 64'd0);
    check("lat1_valid", 64'(out_valid1), 64'd1);
    step();
    check("lat2_valid", 64'(out_valid2), 64'd1);
    check("add_wrap_s", 64'(s2), 64'd0);
    check("add_wrap_flags", 64'({cout2, zero2}), 64'b11);
    repeat (2) step();

    // Signed sub overflow, wrapped then saturated.
    drive(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    sat = 1'b1;
    step();
    in_valid = 1'b0;
    check("ssub_wrap", 64'({s2, ovf2, cout2}), {30'd0, 32'h7FFF_FFFF, 2'b10});
    step();
    check("ssub_sat", 64'({s2, ovf2}), {31'd0, (SatEn ? 32'h8000_0000 : 32'h7FFF_FFFF), 1'b1});
    repeat (2) step();

    // Unsigned sub with borrow-in, wrapped then saturated.
    drive(32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    sat = 1'b1;
    step();
    in_valid = 1'b0;
    check("usub_wrap", 64'({s2, cout2}), {31'd0, 32'hFFFF_FFFF, 1'b1});
    step();
    check("usub_sat", 64'({s2, cout2}), {31'd0, (SatEn ? 32'h0 : 32'hFFFF_FFFF), 1'b1});
    repeat (2) step();

    // Backpressure: sink stalls 3 cycles while 4 bundles are offered.
    sent = 0;
    set_rand(); in_valid = 1'b1;
    for (int cyc = 0; cyc < 20 && (sent < 4 || q2.size() != 0); cyc++) begin
      out_ready2 = (cyc >= 3);
      out_ready1 = (cyc >= 3);
      if (cyc == 2) check("bp_in_ready_low", 64'(in_ready2), 64'd0);
      if (in_valid && in_ready2) begin
        sent++;
        step();
        if (sent < 4) set_rand();
        else in_valid = 1'b0;
      end else begin
        step();
      end
    end
    in_valid = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    check("bp_all_sent", 64'(sent), 64'd4);
    check("bp_all_drained", 64'(q2.size()), 64'd0);
    repeat (2) step();

    // Reset with two bundles in flight.
    set_rand(); in_valid = 1'b1; step();
    set_rand(); step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_valid2", 64'(out_valid2), 64'd0);
    check("rst_mid_valid1", 64'(out_valid1), 64'd0);
    check("rst_mid_s2", 64'(s2), 64'd0);
    repeat (4) step();

    // Streaming at full rate.
    for (int k = 0; k < 8; k++) begin
      set_rand(); in_valid = 1'b1;
      check("stream_in_ready1", 64'(in_ready1), 64'd1);
      step();
      check("stream_valid1", 64'(out_valid1), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end_valid1", 64'(out_valid1), 64'd0);
    step();

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      set_rand();
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 3) != 0);
      out_ready2 = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; out_ready1 = 1'b1; out_ready2 = 1'b1;
    repeat (4) step();
    check("final_q2_empty", 64'(q2.size()), 64'd0);
    check("final_q1_empty", 64'(q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter N, default 32: operand/result width, legal range 4..64.
REQ-002 SHALL have parameter STAGES, default 2: accept-to-output latency in cycles, legal values 1 or 2.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: synchronous active-high reset, sampled on posedge clk.
REQ-005 SHALL have port in_valid, input, 1: operand bundle valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts the bundle this cycle.
REQ-007 SHALL have port a, input, N: operand A.
REQ-008 SHALL have port b, input, N: operand B.
REQ-009 SHALL have port cin, input, 1: carry-in (add) or borrow-in (sub).
REQ-010 SHALL have port op, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port sgn, input, 1: 1 = operands are two's complement for flags/saturation.
REQ-012 SHALL have port out_valid, output, 1: result bundle valid.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the result this cycle.
REQ-014 SHALL have port s, output, N: result.
REQ-015 SHALL have port cout, output, 1: carry (add) or borrow (sub), unsigned sense.
REQ-016 SHALL have port ovf, output, 1: signed overflow, valid only when sgn=1, else 0.
REQ-017 SHALL have port zero, output, 1: s == 0.
REQ-018 SHALL have port neg, output, 1: s[N-1] when sgn=1, else 0.

Function
REQ-019 SHALL accept a bundle on a cycle where in_valid && in_ready.
REQ-020 SHALL compute add as {cout,s} = a + b + cin, at N+1 bits.
REQ-021 SHALL compute sub as s = (a - b - cin) mod 2^N, with cout=1 iff a < b + cin unsigned.
REQ-022 SHALL set ovf=1 for signed add iff a and b have equal signs and s's sign differs from them.
REQ-023 SHALL set ovf=1 for signed sub iff a and b have differing signs and s's sign differs from a.
REQ-024 SHALL present the result of an accepted bundle with out_valid=1 exactly STAGES cycles after acceptance, when no stall occurs.
REQ-025 SHALL behave as a pipeline of STAGES registers, each with its own valid bit.
REQ-026 SHALL advance a stage when its downstream stage is empty or advancing; the last stage advances on out_ready.
REQ-027 SHALL drive in_ready = !(all stages valid) || out_ready, combinationally.
REQ-028 SHALL sustain full throughput of one result per cycle when out_ready=1 continuously.
REQ-029 SHALL hold s, cout, ovf, zero and neg stable while out_valid && !out_ready.
REQ-030 SHALL neither drop nor duplicate bundles; results emerge in acceptance order.
REQ-031 SHALL treat simultaneous accept and emit when full as legal: one result leaves and one bundle enters in the same cycle.
REQ-032 SHALL give results independent of the values on a, b, cin, op and sgn on cycles without acceptance.

Reset
REQ-033 SHALL, when rst=1 at posedge clk, clear all stage valid bits and force out_valid=0, s=0, cout=0, ovf=0, zero=0 and neg=0.
REQ-034 SHALL discard in-flight bundles on reset mid-operation; no result of them ever appears.
REQ-035 SHALL hold in_ready=0 while rst=1.
REQ-036 SHALL have in_ready=1 on the first cycle after rst is deasserted.

Configuration
REQ-037 SHALL, with macro ADDSUB_SAT_EN defined, add input port sat (1 bit).
REQ-038 SHALL, when sat=1 and sgn=1, clamp s on signed overflow to 2^(N-1)-1 on positive overflow and -2^(N-1) on negative overflow, with ovf still asserted.
REQ-039 SHALL, when sat=1 and sgn=0, clamp s to all-ones on add carry and to zero on sub borrow, with cout still asserted.
REQ-040 SHALL, without ADDSUB_SAT_EN, have no sat port and always wrap modulo 2^N.

Verification
REQ-041 SHALL cover, with N=32, STAGES=2: add a=0xFFFFFFFF, b=0x1, cin=0 -> after 2 cycles s=0, cout=1, zero=1.
REQ-042 SHALL cover sub sgn=1: a=0x80000000, b=0x1, cin=0 -> s=0x7FFFFFFF, ovf=1, cout=0; with sat=1 -> s=0x80000000, ovf=1.
REQ-043 SHALL cover unsigned sub: a=5, b=5, cin=1 -> s=0xFFFFFFFF, cout=1; with sat=1 and sgn=0 -> s=0.
REQ-044 SHALL cover backpressure: 4 back-to-back bundles with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, s held stable, all 4 results delivered in order.
REQ-045 SHALL cover reset mid-operation: rst pulsed while 2 bundles are in flight -> out_valid=0 next cycle and neither result ever appears.
REQ-046 SHALL cover STAGES=1 streaming of 8 bundles with out_ready=1 -> one result per cycle at latency 1.
